// File: rtl/fetch_queue.sv
// Fetch queue: a two-wide circular buffer that decouples the fetch stage from decode.
// Each entry carries the instruction, its PC and the branch prediction made for it.
module fetch_queue #(
  parameter int DEPTH           = 8,
  parameter int INST_WIDTH      = 32,
  parameter int INST_ADDR_WIDTH = 32,
  parameter int BP_GHR_BITS     = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic [INST_ADDR_WIDTH-1:0] in_inst_addr_0,
  input  logic [INST_ADDR_WIDTH-1:0] in_inst_addr_1,
  input  logic [INST_WIDTH-1:0]      in_inst_0,
  input  logic [INST_WIDTH-1:0]      in_inst_1,
  input  logic [1:0]                 in_inst_valid,
  input  logic                       in_pred_taken_0,
  input  logic                       in_pred_taken_1,
  input  logic [INST_ADDR_WIDTH-1:0] in_pred_target_0,
  input  logic [INST_ADDR_WIDTH-1:0] in_pred_target_1,
  input  logic [BP_GHR_BITS-1:0]     in_pred_hist_0,
  input  logic [BP_GHR_BITS-1:0]     in_pred_hist_1,
  output logic                       fq_stall,
  input  logic                       dec_ready,
  output logic [INST_ADDR_WIDTH-1:0] out_inst_addr_0,
  output logic [INST_ADDR_WIDTH-1:0] out_inst_addr_1,
  output logic [INST_WIDTH-1:0]      out_inst_0,
  output logic [INST_WIDTH-1:0]      out_inst_1,
  output logic                       out_pred_taken_0,
  output logic                       out_pred_taken_1,
  output logic [INST_ADDR_WIDTH-1:0] out_pred_target_0,
  output logic [INST_ADDR_WIDTH-1:0] out_pred_target_1,
  output logic [BP_GHR_BITS-1:0]     out_pred_hist_0,
  output logic [BP_GHR_BITS-1:0]     out_pred_hist_1,
  output logic [1:0]                 out_inst_valid,
  output logic [$clog2(DEPTH):0]     fq_count,
  output logic                       overflow_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [INST_ADDR_WIDTH-1:0] addr;
    logic [INST_WIDTH-1:0]      inst;
    logic                       pred_taken;
    logic [INST_ADDR_WIDTH-1:0] pred_target;
    logic [BP_GHR_BITS-1:0]     pred_hist;
  } entry_t;

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;

  logic [PTR_W-1:0] head_p1;
  logic [PTR_W-1:0] tail_p1;
  logic [1:0]       valid;
  logic [1:0]       n_in;
  logic [1:0]       n_deq;
  logic [1:0]       n_enq;
  logic             drop;
  logic [CNT_W-1:0] free_slots;
  entry_t           in_e0;
  entry_t           in_e1;
  entry_t           first_e;
  entry_t           head_e0;
  entry_t           head_e1;

  // DEPTH is a power of two, so pointer arithmetic wraps on its own
  assign head_p1 = head + 1'b1;
  assign tail_p1 = tail + 1'b1;

  assign in_e0 = '{addr: in_inst_addr_0, inst: in_inst_0, pred_taken: in_pred_taken_0,
                   pred_target: in_pred_target_0, pred_hist: in_pred_hist_0};
  assign in_e1 = '{addr: in_inst_addr_1, inst: in_inst_1, pred_taken: in_pred_taken_1,
                   pred_target: in_pred_target_1, pred_hist: in_pred_hist_1};

  // A lone slot1 is compacted down so it lands in a single entry at the tail
  assign first_e = in_inst_valid[0] ? in_e0 : in_e1;

  always_comb begin
    valid = 2'b00;
    if (!flush) begin
      if (count >= CNT_W'(2)) begin
        valid = 2'b11;
      end else if (count == CNT_W'(1)) begin
        valid = 2'b01;
      end
    end
  end

  assign n_in  = {1'b0, in_inst_valid[0]} + {1'b0, in_inst_valid[1]};
  assign n_deq = (dec_ready && !flush) ? ({1'b0, valid[0]} + {1'b0, valid[1]}) : 2'd0;

  // Entries leaving this cycle are reusable by this cycle's enqueue
  assign free_slots = CNT_W'(DEPTH) - count + CNT_W'(n_deq);

  always_comb begin
    n_enq = 2'd0;
    drop  = 1'b0;
    if (!flush) begin
      if (CNT_W'(n_in) <= free_slots) begin
        n_enq = n_in;
      end else begin
        n_enq = free_slots[1:0];
        drop  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      overflow_err <= 1'b0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PTR_W'(n_deq);
      tail  <= tail + PTR_W'(n_enq);
      count <= count + CNT_W'(n_enq) - CNT_W'(n_deq);
      if (drop) begin
        overflow_err <= 1'b1;
      end
    end
  end

  // Storage is left unreset; the count masks any stale contents
  always_ff @(posedge clk) begin
    if (n_enq != 2'd0) begin
      mem[tail] <= first_e;
    end
    if (n_enq == 2'd2) begin
      mem[tail_p1] <= in_e1;
    end
  end

  assign head_e0 = valid[0] ? mem[head]    : '0;
  assign head_e1 = valid[1] ? mem[head_p1] : '0;

  assign out_inst_addr_0   = head_e0.addr;
  assign out_inst_0        = head_e0.inst;
  assign out_pred_taken_0  = head_e0.pred_taken;
  assign out_pred_target_0 = head_e0.pred_target;
  assign out_pred_hist_0   = head_e0.pred_hist;

  assign out_inst_addr_1   = head_e1.addr;
  assign out_inst_1        = head_e1.inst;
  assign out_pred_taken_1  = head_e1.pred_taken;
  assign out_pred_target_1 = head_e1.pred_target;
  assign out_pred_hist_1   = head_e1.pred_hist;

  assign out_inst_valid = valid;
  assign fq_count       = count;

  // Margin of four covers the batch in flight plus the one already launched
  assign fq_stall = count > CNT_W'(DEPTH - 4);

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: a queue scoreboard models the expected
// queue contents and each test task compares the presented head entries against it.
module tb_fetch_queue;

  localparam int DEPTH = 8;
  localparam int AW    = 32;
  localparam int IW    = 32;
  localparam int GW    = 8;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [IW-1:0] inst;
    logic          taken;
    logic [AW-1:0] target;
    logic [GW-1:0] hist;
  } entry_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic          dec_ready;
  logic [1:0]    in_inst_valid;
  entry_t        drv0;
  entry_t        drv1;
  logic          fq_stall;
  logic [AW-1:0] out_inst_addr_0, out_inst_addr_1;
  logic [IW-1:0] out_inst_0, out_inst_1;
  logic          out_pred_taken_0, out_pred_taken_1;
  logic [AW-1:0] out_pred_target_0, out_pred_target_1;
  logic [GW-1:0] out_pred_hist_0, out_pred_hist_1;
  logic [1:0]    out_inst_valid;
  logic [3:0]    fq_count;
  logic          overflow_err;

  int     checks   = 0;
  int     failures = 0;
  entry_t sb[$];
  logic   model_ovf;

  always #5 clk = ~clk;

  fetch_queue #(.DEPTH(DEPTH), .INST_WIDTH(IW), .INST_ADDR_WIDTH(AW), .BP_GHR_BITS(GW)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .flush            (flush),
    .in_inst_addr_0   (drv0.addr),
    .in_inst_addr_1   (drv1.addr),
    .in_inst_0        (drv0.inst),
    .in_inst_1        (drv1.inst),
    .in_inst_valid    (in_inst_valid),
    .in_pred_taken_0  (drv0.taken),
    .in_pred_taken_1  (drv1.taken),
    .in_pred_target_0 (drv0.target),
    .in_pred_target_1 (drv1.target),
    .in_pred_hist_0   (drv0.hist),
    .in_pred_hist_1   (drv1.hist),
    .fq_stall         (fq_stall),
    .dec_ready        (dec_ready),
    .out_inst_addr_0  (out_inst_addr_0),
    .out_inst_addr_1  (out_inst_addr_1),
    .out_inst_0       (out_inst_0),
    .out_inst_1       (out_inst_1),
    .out_pred_taken_0 (out_pred_taken_0),
    .out_pred_taken_1 (out_pred_taken_1),
    .out_pred_target_0(out_pred_target_0),
    .out_pred_target_1(out_pred_target_1),
    .out_pred_hist_0  (out_pred_hist_0),
    .out_pred_hist_1  (out_pred_hist_1),
    .out_inst_valid   (out_inst_valid),
    .fq_count         (fq_count),
    .overflow_err     (overflow_err)
  );

  // Entry contents are derived from the PC so every field is distinct per entry
  function automatic entry_t mk(logic [AW-1:0] a);
    entry_t e;
    e.addr   = a;
    e.inst   = {a[15:0], ~a[15:0]} ^ 32'h1357_9bdf;
    e.taken  = a[3];
    e.target = a + 32'h40;
    e.hist   = a[9:2] ^ 8'h5a;
    return e;
  endfunction

  function automatic entry_t got_slot(int i);
    if (i == 0) return {out_inst_addr_0, out_inst_0, out_pred_taken_0, out_pred_target_0, out_pred_hist_0};
    return {out_inst_addr_1, out_inst_1, out_pred_taken_1, out_pred_target_1, out_pred_hist_1};
  endfunction

  function automatic entry_t exp_slot(int i);
    if (flush) return '0;
    if (sb.size() > i) return sb[i];
    return '0;
  endfunction

  function automatic logic [1:0] exp_valid();
    if (flush) return 2'b00;
    if (sb.size() >= 2) return 2'b11;
    if (sb.size() == 1) return 2'b01;
    return 2'b00;
  endfunction

  task automatic drive(logic [1:0] mask, logic [AW-1:0] a0, logic [AW-1:0] a1, logic ready, logic fl);
    drv0          = mk(a0);
    drv1          = mk(a1);
    in_inst_valid = mask;
    dec_ready     = ready;
    flush         = fl;
    #1;
  endtask

  // Advances the scoreboard by what the current inputs should do, then clocks the DUT
  task automatic tick();
    if (flush) begin
      sb.delete();
    end else begin
      int nd = 0;
      if (dec_ready) nd = (sb.size() >= 2) ? 2 : sb.size();
      repeat (nd) void'(sb.pop_front());
      if (in_inst_valid[0]) begin
        if (sb.size() < DEPTH) sb.push_back(drv0); else model_ovf = 1'b1;
      end
      if (in_inst_valid[1]) begin
        if (sb.size() < DEPTH) sb.push_back(drv1); else model_ovf = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(2'b00, '0, '0, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    sb.delete();
    model_ovf = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(2'b11, 32'h40, 32'h44, 1'b1, 1'b0);
    #1;
    checks++; if (fq_count !== 4'd0) begin failures++; $display("[TB] FAIL reset_count: got %0d expected 0", fq_count); end
    checks++; if (out_inst_valid !== 2'b00) begin failures++; $display("[TB] FAIL reset_valid: got %b expected 00", out_inst_valid); end
    checks++; if (fq_stall !== 1'b0) begin failures++; $display("[TB] FAIL reset_stall: got %b expected 0", fq_stall); end
    checks++; if (overflow_err !== 1'b0) begin failures++; $display("[TB] FAIL reset_ovf: got %b expected 0", overflow_err); end
    @(posedge clk);
    #1;
    checks++; if (fq_count !== 4'd0) begin failures++; $display("[TB] FAIL reset_held_count: got %0d expected 0", fq_count); end
    rst_n = 1'b1;
    sb.delete();
    model_ovf = 1'b0;
    drive(2'b00, '0, '0, 1'b0, 1'b0);
    checks++; if (got_slot(0) !== entry_t'(0)) begin failures++; $display("[TB] FAIL reset_slot0: got %h expected 0", got_slot(0)); end
    checks++; if (got_slot(1) !== entry_t'(0)) begin failures++; $display("[TB] FAIL reset_slot1: got %h expected 0", got_slot(1)); end
    checks++; if (out_inst_valid !== 2'b00) begin failures++; $display("[TB] FAIL reset_post_valid: got %b expected 00", out_inst_valid); end
  endtask

  task automatic test_basic();
    do_reset();
    drive(2'b11, 32'h100, 32'h104, 1'b0, 1'b0);
    checks++; if (out_inst_valid !== 2'b00) begin failures++; $display("[TB] FAIL basic_no_bypass: got %b expected 00", out_inst_valid); end
    tick();
    drive(2'b00, '0, '0, 1'b0, 1'b0);
    checks++; if (out_inst_valid !== 2'b11) begin failures++; $display("[TB] FAIL basic_valid: got %b expected 11", out_inst_valid); end
    checks++; if (out_inst_addr_0 !== 32'h100) begin failures++; $display("[TB] FAIL basic_addr0: got %h expected 100", out_inst_addr_0); end
    checks++; if (out_inst_addr_1 !== 32'h104) begin failures++; $display("[TB] FAIL basic_addr1: got %h expected 104", out_inst_addr_1); end
    checks++; if (fq_count !== 4'd2) begin failures++; $display("[TB] FAIL basic_count: got %0d expected 2", fq_count); end
    checks++; if (got_slot(0) !== exp_slot(0)) begin failures++; $display("[TB] FAIL basic_slot0: got %h expected %h", got_slot(0), exp_slot(0)); end
    checks++; if (got_slot(1) !== exp_slot(1)) begin failures++; $display("[TB] FAIL basic_slot1: got %h expected %h", got_slot(1), exp_slot(1)); end
    drive(2'b00, '0, '0, 1'b1, 1'b0);
    tick();
    drive(2'b00, '0, '0, 1'b0, 1'b0);
    checks++; if (fq_count !== 4'd0) begin failures++; $display("[TB] FAIL basic_drain: got %0d expected 0", fq_count); end
  endtask

  task automatic test_stall_overflow();
    int exp_cnt;
    do_reset();
    for (int b = 0; b < 5; b++) begin
      drive(2'b11, 32'h400 + 32'(16 * b), 32'h404 + 32'(16 * b), 1'b0, 1'b0);
      tick();
      drive(2'b00, '0, '0, 1'b0, 1'b0);
      exp_cnt = (b < 4) ? 2 * (b + 1) : 8;
      checks++; if (fq_count !== 4'(exp_cnt)) begin failures++; $display("[TB] FAIL stall_count_b%0d: got %0d expected %0d", b, fq_count, exp_cnt); end
      checks++; if (fq_stall !== (exp_cnt > 4)) begin failures++; $display("[TB] FAIL stall_flag_b%0d: got %b expected %b", b, fq_stall, exp_cnt > 4); end
      checks++; if (overflow_err !== (b == 4)) begin failures++; $display("[TB] FAIL ovf_b%0d: got %b expected %b", b, overflow_err, b == 4); end
    end
    checks++; if (got_slot(0) !== mk(32'h400)) begin failures++; $display("[TB] FAIL full_head0: got %h expected %h", got_slot(0), mk(32'h400)); end
    checks++; if (got_slot(1) !== mk(32'h404)) begin failures++; $display("[TB] FAIL full_head1: got %h expected %h", got_slot(1), mk(32'h404)); end
    drive(2'b00, '0, '0, 1'b0, 1'b1);
    checks++; if (out_inst_valid !== 2'b00) begin failures++; $display("[TB] FAIL flush_mask: got %b expected 00", out_inst_valid); end
    tick();
    drive(2'b00, '0, '0, 1'b0, 1'b0);
    checks++; if (fq_count !== 4'd0) begin failures++; $display("[TB] FAIL flush_full_count: got %0d expected 0", fq_count); end
    checks++; if (overflow_err !== 1'b1) begin failures++; $display("[TB] FAIL ovf_sticky: got %b expected 1", overflow_err); end
  endtask

  task automatic test_same_cycle();
    do_reset();
    drive(2'b01, 32'h500, 32'h0, 1'b0, 1'b0);
    tick();
    drive(2'b01, 32'h510, 32'h0, 1'b1, 1'b0);
    checks++; if (out_inst_valid !== 2'b01) begin failures++; $display("[TB] FAIL same_valid_pre: got %b expected 01", out_inst_valid); end
    checks++; if (got_slot(0) !== mk(32'h500)) begin failures++; $display("[TB] FAIL same_slot0_pre: got %h expected %h", got_slot(0), mk(32'h500)); end
    tick();
    drive(2'b00, '0, '0, 1'b0, 1'b0);
    checks++; if (fq_count !== 4'd1) begin failures++; $display("[TB] FAIL same_count: got %0d expected 1", fq_count); end
    checks++; if (got_slot(0) !== mk(32'h510)) begin failures++; $display("[TB] FAIL same_slot0_post: got %h expected %h", got_slot(0), mk(32'h510)); end
    checks++; if (got_slot(1) !== entry_t'(0)) begin failures++; $display("[TB] FAIL same_slot1_zero: got %h expected 0", got_slot(1)); end
  endtask

  task automatic test_wrap();
    logic [AW-1:0] a;
    do_reset();
    a = 32'h600;
    // One single entry then four pairs with decode draining leaves head at index 7
    for (int c = 0; c < 6; c++) begin
      if (c == 0) begin
        drive(2'b01, a, 32'h0, 1'b0, 1'b0);
        a = a + 32'h4;
      end else begin
        drive(2'b11, a, a + 32'h4, 1'b1, 1'b0);
        a = a + 32'h8;
      end
      tick();
      drive(2'b00, '0, '0, 1'b0, 1'b0);
      checks++; if (fq_count !== 4'(sb.size())) begin failures++; $display("[TB] FAIL wrap_count_c%0d: got %0d expected %0d", c, fq_count, sb.size()); end
      checks++; if (got_slot(0) !== exp_slot(0)) begin failures++; $display("[TB] FAIL wrap_slot0_c%0d: got %h expected %h", c, got_slot(0), exp_slot(0)); end
      checks++; if (got_slot(1) !== exp_slot(1)) begin failures++; $display("[TB] FAIL wrap_slot1_c%0d: got %h expected %h", c, got_slot(1), exp_slot(1)); end
      if (c == 4) begin
        checks++; if (out_inst_addr_0 !== 32'h61c) begin failures++; $display("[TB] FAIL wrap_addr0: got %h expected 61c", out_inst_addr_0); end
        checks++; if (out_inst_addr_1 !== 32'h620) begin failures++; $display("[TB] FAIL wrap_addr1: got %h expected 620", out_inst_addr_1); end
      end
    end
  endtask

  task automatic test_flush();
    do_reset();
    drive(2'b11, 32'h700, 32'h704, 1'b0, 1'b0);
    tick();
    drive(2'b11, 32'h708, 32'h70c, 1'b0, 1'b0);
    tick();
    drive(2'b01, 32'h710, 32'h0, 1'b0, 1'b0);
    tick();
    drive(2'b11, 32'h720, 32'h724, 1'b1, 1'b1);
    checks++; if (fq_count !== 4'd5) begin failures++; $display("[TB] FAIL flush_pre_count: got %0d expected 5", fq_count); end
    checks++; if (got_slot(0) !== entry_t'(0)) begin failures++; $display("[TB] FAIL flush_slot0_zero: got %h expected 0", got_slot(0)); end
    tick();
    drive(2'b00, '0, '0, 1'b0, 1'b0);
    checks++; if (fq_count !== 4'd0) begin failures++; $display("[TB] FAIL flush_count: got %0d expected 0", fq_count); end
    checks++; if (out_inst_valid !== 2'b00) begin failures++; $display("[TB] FAIL flush_valid: got %b expected 00", out_inst_valid); end
    checks++; if (overflow_err !== 1'b0) begin failures++; $display("[TB] FAIL flush_ovf: got %b expected 0", overflow_err); end
    drive(2'b01, 32'h730, 32'h0, 1'b0, 1'b0);
    tick();
    drive(2'b00, '0, '0, 1'b0, 1'b0);
    checks++; if (got_slot(0) !== mk(32'h730)) begin failures++; $display("[TB] FAIL flush_refill: got %h expected %h", got_slot(0), mk(32'h730)); end
    checks++; if (fq_count !== 4'd1) begin failures++; $display("[TB] FAIL flush_refill_count: got %0d expected 1", fq_count); end
  endtask

  task automatic test_mask10();
    entry_t e;
    do_reset();
    drive(2'b10, 32'h999, 32'h208, 1'b0, 1'b0);
    drv1.taken = 1'b1;
    e = drv1;
    #1;
    tick();
    drive(2'b00, '0, '0, 1'b0, 1'b0);
    checks++; if (out_inst_valid !== 2'b01) begin failures++; $display("[TB] FAIL m10_valid: got %b expected 01", out_inst_valid); end
    checks++; if (out_inst_addr_0 !== 32'h208) begin failures++; $display("[TB] FAIL m10_addr0: got %h expected 208", out_inst_addr_0); end
    checks++; if (out_pred_taken_0 !== 1'b1) begin failures++; $display("[TB] FAIL m10_taken0: got %b expected 1", out_pred_taken_0); end
    checks++; if (got_slot(0) !== e) begin failures++; $display("[TB] FAIL m10_slot0: got %h expected %h", got_slot(0), e); end
    checks++; if (fq_count !== 4'd1) begin failures++; $display("[TB] FAIL m10_count: got %0d expected 1", fq_count); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    drive(2'b11, 32'h800, 32'h804, 1'b0, 1'b0);
    tick();
    drive(2'b11, 32'h808, 32'h80c, 1'b0, 1'b0);
    tick();
    drive(2'b00, '0, '0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    checks++; if (fq_count !== 4'd0) begin failures++; $display("[TB] FAIL midrst_count: got %0d expected 0", fq_count); end
    checks++; if (out_inst_valid !== 2'b00) begin failures++; $display("[TB] FAIL midrst_valid: got %b expected 00", out_inst_valid); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    sb.delete();
    model_ovf = 1'b0;
    drive(2'b01, 32'h820, 32'h0, 1'b0, 1'b0);
    tick();
    drive(2'b00, '0, '0, 1'b0, 1'b0);
    checks++; if (got_slot(0) !== mk(32'h820)) begin failures++; $display("[TB] FAIL midrst_slot0: got %h expected %h", got_slot(0), mk(32'h820)); end
    checks++; if (fq_count !== 4'd1) begin failures++; $display("[TB] FAIL midrst_refill: got %0d expected 1", fq_count); end
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] a;
    logic          ready;
    logic          fl;
    do_reset();
    a = 32'h1000;
    for (int c = 0; c < 240; c++) begin
      // Slow decode for the first half fills the queue; fast decode then drains it
      ready = (c < 120) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      fl    = ($urandom_range(0, 39) == 0);
      drive(2'($urandom_range(0, 3)), a, a + 32'h4, ready, fl);
      a = a + 32'h8;
      checks++; if (out_inst_valid !== exp_valid()) begin failures++; $display("[TB] FAIL b2b_valid_c%0d: got %b expected %b", c, out_inst_valid, exp_valid()); end
      checks++; if (got_slot(0) !== exp_slot(0)) begin failures++; $display("[TB] FAIL b2b_slot0_c%0d: got %h expected %h", c, got_slot(0), exp_slot(0)); end
      checks++; if (got_slot(1) !== exp_slot(1)) begin failures++; $display("[TB] FAIL b2b_slot1_c%0d: got %h expected %h", c, got_slot(1), exp_slot(1)); end
      checks++; if (fq_count !== 4'(sb.size())) begin failures++; $display("[TB] FAIL b2b_count_c%0d: got %0d expected %0d", c, fq_count, sb.size()); end
      checks++; if (fq_stall !== (sb.size() > DEPTH - 4)) begin failures++; $display("[TB] FAIL b2b_stall_c%0d: got %b expected %b", c, fq_stall, sb.size() > DEPTH - 4); end
      checks++; if (overflow_err !== model_ovf) begin failures++; $display("[TB] FAIL b2b_ovf_c%0d: got %b expected %b", c, overflow_err, model_ovf); end
      tick();
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    model_ovf = 1'b0;
    drive(2'b00, '0, '0, 1'b0, 1'b0);
    test_reset();
    test_basic();
    test_stall_overflow();
    test_same_cycle();
    test_wrap();
    test_flush();
    test_mask10();
    test_mid_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
